// File: rtl/uart_tx_drain.sv
// Drains a show-ahead FIFO onto an 8N1 UART line, one byte per frame.
// Pop is combinational from state so a queued byte is taken in its first IDLE cycle.
module uart_tx_drain #(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_pop,
   output logic       tx,
   output logic       tx_busy
);

   localparam int BIT_CYC = CLK_HZ / BAUD;
   localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t        state_r;
   logic [CW-1:0] cnt_r;
   logic [2:0]    bit_idx_r;
   logic [7:0]    shift_r;
   logic          tx_r;
   logic          busy_r;
   logic          bit_end_s;

   // last cycle of the current bit period
   always_comb begin
      bit_end_s = 1'b0;
      if (cnt_r == CNT_LAST) begin
         bit_end_s = 1'b1;
      end else begin
         bit_end_s = 1'b0;
      end
   end

   // pop strobe: only in IDLE, never during reset or with an empty FIFO
   always_comb begin
      fifo_pop = 1'b0;
      if (!rst && (state_r == IDLE) && !fifo_empty) begin
         fifo_pop = 1'b1;
      end else begin
         fifo_pop = 1'b0;
      end
   end

   // frame sequencer; tx is loaded one cycle ahead so it changes only at bit boundaries
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= CNT_ZERO;
         bit_idx_r <= 3'd0;
         shift_r   <= 8'h00;
         tx_r      <= 1'b1;
         busy_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (!fifo_empty) begin
                  shift_r   <= fifo_data;
                  cnt_r     <= CNT_ZERO;
                  bit_idx_r <= 3'd0;
                  tx_r      <= 1'b0;
                  busy_r    <= 1'b1;
                  state_r   <= START;
               end else begin
                  tx_r   <= 1'b1;
                  busy_r <= 1'b0;
               end
            end
            START: begin
               if (bit_end_s) begin
                  cnt_r     <= CNT_ZERO;
                  bit_idx_r <= 3'd0;
                  tx_r      <= shift_r[0];
                  state_r   <= DATA;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            DATA: begin
               if (bit_end_s) begin
                  cnt_r   <= CNT_ZERO;
                  shift_r <= {1'b0, shift_r[7:1]};
                  if (bit_idx_r == 3'd7) begin
                     tx_r    <= 1'b1;
                     state_r <= STOP;
                  end else begin
                     tx_r      <= shift_r[1];
                     bit_idx_r <= bit_idx_r + 3'd1;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            STOP: begin
               if (bit_end_s) begin
                  cnt_r     <= CNT_ZERO;
                  bit_idx_r <= 3'd0;
                  busy_r    <= 1'b0;
                  state_r   <= IDLE;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r   <= IDLE;
               cnt_r     <= CNT_ZERO;
               bit_idx_r <= 3'd0;
               tx_r      <= 1'b1;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end

   assign tx      = tx_r;
   assign tx_busy = busy_r;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: FIFO model plus a line log checked against a per-bit
// frame model and an independent mid-bit UART decoder.
module tb_uart_tx_drain;

   localparam int CLK_HZ  = 1000;
   localparam int BAUD    = 100;
   localparam int BIT_CYC = CLK_HZ / BAUD;
   localparam int FRAME   = 10 * BIT_CYC;

   logic       clk = 1'b0;
   logic       rst;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_pop;
   logic       tx;
   logic       tx_busy;

   logic [7:0] fifo_q[$];
   bit         tx_log[$];
   bit         busy_log[$];
   bit         pop_log[$];
   int         cyc          = 0;
   int         checks       = 0;
   int         fails        = 0;
   int         illegal_pops = 0;
   bit         scramble     = 1'b0;

   always #5 clk = ~clk;

   uart_tx_drain #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
      .clk       (clk),
      .rst       (rst),
      .fifo_empty(fifo_empty),
      .fifo_data (fifo_data),
      .fifo_pop  (fifo_pop),
      .tx        (tx),
      .tx_busy   (tx_busy)
   );

   assert property (@(posedge clk) fifo_pop |-> (!fifo_empty && !tx_busy && !rst))
      else illegal_pops++;

   task automatic drive();
      if (scramble) begin
         fifo_empty = 1'($urandom_range(0, 1));
         fifo_data  = 8'($urandom);
      end else begin
         fifo_empty = (fifo_q.size() == 0);
         fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
      end
   endtask

   task automatic tick();
      bit popped;
      @(negedge clk);
      tx_log.push_back(tx);
      busy_log.push_back(tx_busy);
      pop_log.push_back(fifo_pop);
      if (fifo_pop && (fifo_empty || tx_busy || rst)) illegal_pops++;
      popped = fifo_pop;
      @(posedge clk);
      #1;
      cyc++;
      if (popped && fifo_q.size() != 0) void'(fifo_q.pop_front());
      drive();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_pop(input int budget, output int p);
      p = -1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (pop_log[cyc-1]) begin
            p = cyc - 1;
            break;
         end
      end
      checks++;
      if (p < 0) begin
         fails++;
         $display("FAIL pop_timeout: no pop within %0d cycles (cycle %0d)", budget, cyc);
      end
   endtask

   // expected line level at offset off (0..FRAME-1) into a frame carrying b
   function automatic bit exp_tx(input logic [7:0] b, input int off);
      int k;
      k = off / BIT_CYC;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return b[k-1];
   endfunction

   // cycles of a frame popped at cycle p whose tx/tx_busy disagree with the model
   function automatic int frame_errs(input logic [7:0] b, input int p);
      int errs = 0;
      for (int off = 0; off < FRAME; off++) begin
         int c = p + 1 + off;
         if (c >= tx_log.size()) errs++;
         else if (tx_log[c] !== exp_tx(b, off) || busy_log[c] !== 1'b1) errs++;
      end
      return errs;
   endfunction

   // mid-bit decoder: first falling edge at or after 'from'; -1 none, -2 bad stop bit
   function automatic int decode(input int from);
      logic [7:0] v;
      for (int i = from; i + FRAME + 1 < tx_log.size(); i++) begin
         if (tx_log[i] == 1'b1 && tx_log[i+1] == 1'b0) begin
            for (int k = 0; k < 8; k++) v[k] = tx_log[i + 1 + BIT_CYC * (k + 1) + BIT_CYC / 2];
            if (tx_log[i + 1 + BIT_CYC * 9 + BIT_CYC / 2] != 1'b1) return -2;
            return int'(v);
         end
      end
      return -1;
   endfunction

   function automatic int count_log(input int which, input int from, input int to);
      int n = 0;
      for (int c = from; c <= to && c < pop_log.size(); c++) begin
         if (which == 0 && pop_log[c]) n++;
         if (which == 1 && busy_log[c]) n++;
      end
      return n;
   endfunction

   task automatic test_reset();
      int bad_tx = 0, bad_busy = 0, bad_pop = 0;
      rst = 1'b1;
      fifo_empty = 1'b1;
      fifo_data = 8'h00;
      ticks(3);
      for (int c = 0; c < 3; c++) begin
         if (tx_log[c] !== 1'b1) bad_tx++;
         if (busy_log[c] !== 1'b0) bad_busy++;
         if (pop_log[c] !== 1'b0) bad_pop++;
      end
      checks++;
      if (bad_tx + bad_busy + bad_pop !== 0) begin
         fails++;
         $display("FAIL reset_hold: bad cycles tx=%0d busy=%0d pop=%0d, required 0", bad_tx, bad_busy, bad_pop);
      end
      rst = 1'b0;
      ticks(200);
      bad_tx = 0; bad_busy = 0; bad_pop = 0;
      for (int c = 3; c < 203; c++) begin
         if (tx_log[c] !== 1'b1) bad_tx++;
         if (busy_log[c] !== 1'b0) bad_busy++;
         if (pop_log[c] !== 1'b0) bad_pop++;
      end
      checks++;
      if (bad_tx !== 0) begin fails++; $display("FAIL idle_tx: %0d cycles with tx!=1, required 0", bad_tx); end
      checks++;
      if (bad_busy !== 0) begin fails++; $display("FAIL idle_busy: %0d cycles busy, required 0", bad_busy); end
      checks++;
      if (bad_pop !== 0) begin fails++; $display("FAIL idle_pop: %0d pops with empty FIFO, required 0", bad_pop); end
   endtask

   task automatic test_single();
      int p, d, n;
      fifo_q.push_back(8'h55);
      drive();
      wait_pop(20, p);
      if (p >= 0) begin
         ticks(FRAME + 10);
         n = count_log(0, p, p + FRAME + 5);
         checks++;
         if (n !== 1) begin fails++; $display("FAIL single_pops: got %0d pops, required 1", n); end
         n = frame_errs(8'h55, p);
         checks++;
         if (n !== 0) begin fails++; $display("FAIL single_wave: %0d bad cycles, required 0", n); end
         n = count_log(1, p, p + FRAME + 5);
         checks++;
         if (n !== FRAME) begin fails++; $display("FAIL single_busy_len: got %0d, required %0d", n, FRAME); end
         d = decode(p);
         checks++;
         if (d !== 32'h55) begin fails++; $display("FAIL single_decode: got %0d, required %0d", d, 32'h55); end
         checks++;
         if (tx_log[p+FRAME+1] !== 1'b1 || busy_log[p+FRAME+1] !== 1'b0) begin
            fails++;
            $display("FAIL single_after: tx=%0b busy=%0b, required tx=1 busy=0", tx_log[p+FRAME+1], busy_log[p+FRAME+1]);
         end
      end
   endtask

   task automatic test_back_to_back(input logic [7:0] bytes[$]);
      int p0, d, n, nb;
      nb = bytes.size();
      foreach (bytes[i]) fifo_q.push_back(bytes[i]);
      drive();
      wait_pop(20, p0);
      if (p0 >= 0) begin
         ticks(nb * (FRAME + 1) + 10);
         n = count_log(0, p0, p0 + nb * (FRAME + 1) + 5);
         checks++;
         if (n !== nb) begin fails++; $display("FAIL b2b_pop_count: got %0d, required %0d", n, nb); end
         for (int i = 0; i < nb; i++) begin
            int p = p0 + i * (FRAME + 1);
            checks++;
            if (pop_log[p] !== 1'b1) begin fails++; $display("FAIL b2b_pop_at[%0d]: pop=%0b at cycle %0d, required 1", i, pop_log[p], p); end
            d = decode(p);
            checks++;
            if (d !== int'(bytes[i])) begin fails++; $display("FAIL b2b_decode[%0d]: got %0d, required %0d", i, d, bytes[i]); end
            n = frame_errs(bytes[i], p);
            checks++;
            if (n !== 0) begin fails++; $display("FAIL b2b_wave[%0d]: %0d bad cycles, required 0", i, n); end
            checks++;
            if (tx_log[p+FRAME+1] !== 1'b1) begin fails++; $display("FAIL b2b_gap_tx[%0d]: got %0b, required 1", i, tx_log[p+FRAME+1]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      int p, r, d, n;
      logic [7:0] b1;
      b1 = 8'($urandom);
      fifo_q.push_back(8'hC6);
      fifo_q.push_back(b1);
      drive();
      wait_pop(20, p);
      if (p >= 0) begin
         ticks(p + 1 + 4 * BIT_CYC + BIT_CYC / 2 - cyc);
         r = cyc;
         rst = 1'b1;
         ticks(2);
         rst = 1'b0;
         ticks(FRAME + 10);
         checks++;
         if (tx_log[r] !== 1'b0) begin fails++; $display("FAIL rmid_bit3: tx=%0b before reset, required 0", tx_log[r]); end
         checks++;
         if (tx_log[r+1] !== 1'b1 || busy_log[r+1] !== 1'b0) begin
            fails++;
            $display("FAIL rmid_abort: tx=%0b busy=%0b, required tx=1 busy=0", tx_log[r+1], busy_log[r+1]);
         end
         checks++;
         if (pop_log[r] !== 1'b0 || pop_log[r+1] !== 1'b0) begin
            fails++;
            $display("FAIL rmid_pop_in_rst: pops=%0b%0b, required 00", pop_log[r], pop_log[r+1]);
         end
         checks++;
         if (pop_log[r+2] !== 1'b1) begin fails++; $display("FAIL rmid_first_pop: pop=%0b, required 1", pop_log[r+2]); end
         n = count_log(0, p + 1, cyc - 1);
         checks++;
         if (n !== 1) begin fails++; $display("FAIL rmid_repop: got %0d pops after abort, required 1", n); end
         d = decode(r + 2);
         checks++;
         if (d !== int'(b1)) begin fails++; $display("FAIL rmid_decode: got %0d, required %0d", d, b1); end
         n = frame_errs(b1, r + 2);
         checks++;
         if (n !== 0) begin fails++; $display("FAIL rmid_wave: %0d bad cycles, required 0", n); end
      end
   endtask

   task automatic test_scramble();
      int p, d, n;
      fifo_q.push_back(8'h3C);
      drive();
      wait_pop(20, p);
      if (p >= 0) begin
         scramble = 1'b1;
         drive();
         ticks(p + FRAME - 5 - cyc);
         scramble = 1'b0;
         drive();
         ticks(20);
         d = decode(p);
         checks++;
         if (d !== 32'h3C) begin fails++; $display("FAIL scr_decode: got %0d, required %0d", d, 32'h3C); end
         n = frame_errs(8'h3C, p);
         checks++;
         if (n !== 0) begin fails++; $display("FAIL scr_wave: %0d bad cycles, required 0", n); end
         n = count_log(0, p + 1, p + FRAME);
         checks++;
         if (n !== 0) begin fails++; $display("FAIL scr_pops: got %0d pops mid-frame, required 0", n); end
      end
   endtask

   initial begin
      logic [7:0] fixed[$];
      logic [7:0] rnd[$];
      test_reset();
      test_single();
      ticks(5);
      fixed = '{8'h00, 8'hFF, 8'hA3};
      test_back_to_back(fixed);
      ticks(5);
      for (int i = 0; i < 4; i++) rnd.push_back(8'($urandom));
      test_back_to_back(rnd);
      ticks(5);
      test_reset_mid();
      ticks(5);
      test_scramble();
      checks++;
      if (illegal_pops !== 0) begin
         fails++;
         $display("FAIL pop_rule: %0d illegal pops, required 0", illegal_pops);
      end
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
